// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and helpers for the multiplexed 7-segment driver.
//   - active-low segment encodings, bit order [6:0] = G..A
//   - seg_encode(): 4-bit BCD -> 7-bit segment pattern (non-decimal -> blank)
//   - state_t: control FSM state
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {IDLE, CONVERT} state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: serial double-dabble (shift-add-3) binary to BCD converter.
// One extra carry nibble above NUM_DIGITS is kept; anything reaching it (or
// shifted past it) flags overflow.
// Ports:
//   clock_100 : clock
//   reset     : async active-low reset
//   start     : capture bin and clear accumulator (ignored while running)
//   bin       : binary input
//   done      : high during the final step cycle
//   digits    : BCD result as it will be after the current step (valid with done)
//   overflow  : overflow flag as it will be after the current step (valid with done)
module bin2bcd_serial #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                         clock_100,
  input  logic                         reset,
  input  logic                         start,
  input  logic [BIN_WIDTH-1:0]         bin,
  output logic                         done,
  output logic [NUM_DIGITS-1:0][3:0]   digits,
  output logic                         overflow
);

  localparam int NIB = NUM_DIGITS + 1;
  localparam int CW  = $clog2(BIN_WIDTH + 1);

  logic [BIN_WIDTH-1:0]   sh;
  logic [NIB-1:0][3:0]    acc, adj, acc_nxt;
  logic                   ovf, ovf_nxt, run;
  logic [CW-1:0]          cnt;

  // per-nibble add-3 correction
  for (genvar g = 0; g < NIB; g++) begin : g_nib
    assign adj[g] = (acc[g] >= 4'd5) ? acc[g] + 4'd3 : acc[g];
  end

  // shift left one bit, pulling in the next binary MSB
  assign acc_nxt  = {adj[NIB-1][2:0], adj[NIB-2:0], sh[BIN_WIDTH-1]};
  // sticky: once the carry nibble is nonzero the value can only grow
  assign ovf_nxt  = ovf | adj[NIB-1][3] | (acc_nxt[NIB-1] != 4'd0);
  assign done     = run && (cnt == CW'(BIN_WIDTH - 1));
  assign digits   = acc_nxt[NUM_DIGITS-1:0];
  assign overflow = ovf_nxt;

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      sh  <= '0;
      acc <= '0;
      ovf <= 1'b0;
      run <= 1'b0;
      cnt <= '0;
    end else if (start && !run) begin
      sh  <= bin;
      acc <= '0;
      ovf <= 1'b0;
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      sh  <= sh << 1;
      acc <= acc_nxt;
      ovf <= ovf_nxt;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/seg7_multiplex_driver.sv
// seg7_multiplex_driver: load-strobed binary -> BCD conversion, atomic display
// register, and time-multiplexed common-anode scan driven by a clock-enable tick.
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 always shown, dash overflow display unaffected).
// Ports:
//   clock_100 : 100 MHz clock
//   reset     : async active-low reset
//   num       : binary value to display
//   load      : capture strobe, accepted while busy=0
//   busy      : conversion in progress
//   controls  : segments, active-low, [0]=CA .. [6]=CG (registered)
//   seg_ctrl  : digit anodes, active-low, [0]=ones (registered)
module seg7_multiplex_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int DIGIT_TICKS = 100000
) (
  input  logic                  clock_100,
  input  logic                  reset,
  input  logic [BIN_WIDTH-1:0]  num,
  input  logic                  load,
  output logic                  busy,
  output logic [6:0]            controls,
  output logic [NUM_DIGITS-1:0] seg_ctrl
);

  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t                      state, state_nxt;
  logic                        start, cv_done, cv_ovf;
  logic [NUM_DIGITS-1:0][3:0]  cv_digits;
  logic [NUM_DIGITS-1:0][3:0]  disp;
  logic                        disp_dash;
  logic [TW-1:0]               tick;
  logic [IW-1:0]               idx;
  logic [NUM_DIGITS-1:0]       blank;
  logic [6:0]                  seg_nxt;
  logic [NUM_DIGITS-1:0]       an_nxt;

  bin2bcd_serial #(.BIN_WIDTH(BIN_WIDTH), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clock_100 (clock_100),
    .reset     (reset),
    .start     (start),
    .bin       (num),
    .done      (cv_done),
    .digits    (cv_digits),
    .overflow  (cv_ovf)
  );

  // ---- control FSM
  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE:    if (load) begin
                 start     = 1'b1;
                 state_nxt = CONVERT;
               end
      CONVERT: if (cv_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CONVERT);

  // ---- display register: written only on the final conversion step
  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      disp      <= '0;
      disp_dash <= 1'b0;
    end else if (state == CONVERT && cv_done) begin
      disp      <= cv_digits;
      disp_dash <= cv_ovf;
    end
  end

  // ---- scan timing: tick enable, digit index
  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      tick <= '0;
      idx  <= '0;
    end else if (tick == TW'(DIGIT_TICKS - 1)) begin
      tick <= '0;
      idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // ---- leading-zero blanking
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      blank[i] = 1'b1;
      for (int j = i; j < NUM_DIGITS; j++)
        if (disp[j] != 4'd0) blank[i] = 1'b0;
    end
  end
`else
  assign blank = '0;
`endif

  // ---- output selection; registered so segments and anode move together
  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        an_nxt[i] = 1'b0;
        if (disp_dash)     seg_nxt = SEG_DASH;
        else if (blank[i]) seg_nxt = SEG_BLANK;
        else               seg_nxt = seg_encode(disp[i]);
      end
    end
  end

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      controls <= SEG_BLANK;
      seg_ctrl <= '1;
    end else begin
      controls <= seg_nxt;
      seg_ctrl <= an_nxt;
    end
  end

endmodule
